// File: rtl/temp_filter.sv
// Averages blocks of raw sensor samples into whole-degree display temperatures.
// Build option: TEMP_FILTER_ROUND_EN rounds half up instead of flooring.
module temp_filter #(
  parameter int SAMPLE_W = 13,
  parameter int AVG_LOG2 = 3,
  parameter int MAX_C    = 99
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic [7:0]          temp_out,
  output logic                temp_valid,
  output logic                temp_clamped
);

  localparam int ACC_W = SAMPLE_W + AVG_LOG2;
  localparam int DEG_W = ACC_W + 1;
  localparam logic signed [DEG_W-1:0] MAX_S = DEG_W'(MAX_C);
  localparam logic [7:0] MAX_8 = 8'(MAX_C);

  typedef enum logic [1:0] {
    ACC,
    CALC,
    PUB
  } state_t;

  state_t                    state;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_nxt;
  logic signed [ACC_W-1:0]   avg;
  logic signed [DEG_W-1:0]   avg_w;
  logic signed [DEG_W-1:0]   deg;
  logic signed [DEG_W-1:0]   deg_nxt;
  logic [AVG_LOG2-1:0]       cnt;

  assign acc_nxt = acc + {{AVG_LOG2{sample_in[SAMPLE_W-1]}}, sample_in};
  assign avg     = acc >>> AVG_LOG2;
  assign avg_w   = DEG_W'(avg);

`ifdef TEMP_FILTER_ROUND_EN
  localparam logic signed [DEG_W-1:0] HALF = DEG_W'(8);
  logic signed [DEG_W-1:0] rnd;

  always_comb begin
    rnd     = avg_w + HALF;
    deg_nxt = rnd >>> 4;
  end
`else
  always_comb begin
    deg_nxt = avg_w >>> 4;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ACC;
      acc          <= '0;
      cnt          <= '0;
      deg          <= '0;
      sample_ready <= 1'b1;
      temp_out     <= '0;
      temp_valid   <= 1'b0;
      temp_clamped <= 1'b0;
    end else begin
      temp_valid <= 1'b0;
      unique case (state)
        ACC: begin
          if (sample_valid && sample_ready) begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == '1) begin
              state        <= CALC;
              sample_ready <= 1'b0;
            end
          end
        end
        CALC: begin
          deg   <= deg_nxt;
          state <= PUB;
        end
        PUB: begin
          if (deg < 0) begin
            temp_out     <= '0;
            temp_clamped <= 1'b1;
          end else if (deg > MAX_S) begin
            temp_out     <= MAX_8;
            temp_clamped <= 1'b1;
          end else begin
            temp_out     <= deg[7:0];
            temp_clamped <= 1'b0;
          end
          temp_valid   <= 1'b1;
          acc          <= '0;
          cnt          <= '0;
          state        <= ACC;
          sample_ready <= 1'b1;
        end
        default: begin
          state        <= ACC;
          sample_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/temp_filter.md
Name: temp_filter

Overview:
- Sits between the temperature sensor reader and the seven-segment display controller.
- Accepts raw two's-complement sensor samples (1/16 °C LSB, 13-bit sensor mode) over a valid/ready handshake.
- Averages each block of 2^AVG_LOG2 samples, converts the average to whole °C and clamps it to 0..MAX_C.
- Presents the result as the 8-bit binary temperature the display consumes, with a one-cycle update strobe.

Parameters:
- SAMPLE_W, 13: raw sample width, two's complement, LSB = 1/16 °C.
- AVG_LOG2, 3: log2 of samples per average (8 samples).
- MAX_C, 99: upper clamp in °C. Must be ≤ 255; the display shows two digits.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- sample_in  input  SAMPLE_W  raw sensor sample.
- sample_valid  input  1  sample_in is valid this cycle.
- sample_ready  output  1  block can accept a sample this cycle.
- temp_out  output  8  filtered, clamped temperature in whole °C (unsigned).
- temp_valid  output  1  one-cycle pulse when temp_out has just updated.
- temp_clamped  output  1  last published value was clamped (below 0 or above MAX_C).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset, sampled on posedge clk.
- Reset values:
  - state = ACC; accumulator = 0; sample count = 0.
  - sample_ready = 1, temp_out = 0, temp_valid = 0, temp_clamped = 0.
- Handshake:
  - A sample is accepted on a posedge where sample_valid && sample_ready.
  - sample_ready is a registered function of state: 1 only in ACC.
  - The upstream block holds sample_in/sample_valid until accepted.
  - Samples presented while ready = 0 are not consumed and are not lost.
- Accumulator:
  - Width SAMPLE_W + AVG_LOG2, signed.
  - Each accepted sample is sign-extended before being added.
  - No overflow is possible by construction.
- FSM:
  - ACC:
    - On accept: acc += sample, cnt += 1.
    - If this accept is sample number 2^AVG_LOG2 (cnt == 2^AVG_LOG2 − 1 before the accept), go to CALC.
  - CALC (one cycle):
    - avg = acc >>> AVG_LOG2 (arithmetic shift).
    - deg = avg >>> 4 (floor toward −∞). Register deg.
    - Go to PUB.
  - PUB (one cycle):
    - If deg < 0: temp_out = 0, temp_clamped = 1.
    - Else if deg > MAX_C: temp_out = MAX_C, temp_clamped = 1.
    - Else: temp_out = deg[7:0], temp_clamped = 0.
    - Pulse temp_valid; clear acc and cnt; go to ACC.
- Latency:
  - Edge E0 accepts the final sample. E1 registers deg. E2 updates temp_out/temp_clamped and sets temp_valid = 1.
  - temp_valid drops after E3.
  - sample_ready is low for exactly the two cycles between E0 and E2.
- Between updates:
  - temp_out and temp_clamped hold their last published values.
  - temp_valid = 0.
- Partial block: an incomplete block never publishes; there is no timeout.
- Reset mid-operation (any state): partial accumulation is discarded and all outputs return to reset values on the next edge.
- Before the first publish after reset, temp_out reads 0 (the display shows "00").

Optional Feature:
- Macro: TEMP_FILTER_ROUND_EN.
- Defined: CALC uses deg = (avg + 8) >>> 4, i.e. round half up to the nearest °C. The average is widened by one bit before the add so it cannot overflow.
- Undefined: floor as above.
- Latency, handshake and clamping are identical in both builds.

Test Plan:
- Nominal: after reset, 8 back-to-back samples of 0x0190 (25.0 °C) → after E2, temp_out = 25, temp_clamped = 0, temp_valid high for exactly 1 cycle, sample_ready low for exactly 2 cycles.
- Rounding: 8 samples of 0x019F (25.9375 °C) → temp_out = 25. With TEMP_FILTER_ROUND_EN defined → 26.
- Average: four samples of 0x0190 then four of 0x01B0 (27 °C) → avg = 416 → temp_out = 26.
- Clamp low: 8 samples of 0x1FB0 (−5 °C) → temp_out = 0, temp_clamped = 1.
- Clamp high: 8 samples of 0x0960 (150 °C) → temp_out = 99, temp_clamped = 1.
- Backpressure and reset:
  - Hold sample_valid high continuously with an incrementing sample_in → no sample is accepted during CALC/PUB, and the 9th value becomes the 1st sample of the next block.
  - Assert reset after 5 samples of 0x01E0, then apply 8 more samples of 0x01E0 → exactly one publish, temp_out = 30, occurring only after the 8th post-reset sample.
